e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It is the parametrised, multi-cycle companion of the single-cycle E-stage ALU.
- Accepts signed and unsigned mult/div and HI/LO moves from the E stage.
- Models the real latency with a busy countdown and holds the results in architectural HI/LO registers.
- The hazard unit stalls on `busy` (or on `start` in the issuing cycle) for any MDU-dependent instruction. The interrupt/exception logic uses `cancel` to squash an in-flight op.

Parameters:
- WIDTH, 32: operand width; HI/LO are WIDTH bits each.
- MULT_CYCLES, 5: busy cycles for mult/multu. Must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu. Must be ≥1.
- CNT_W, 4: countdown counter width. Must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  issue strobe, one cycle per instruction
- mdu_op  in  3  operation code (see package)
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt
- cancel  in  1  squash in-flight op (exception/interrupt)
- busy  out  1  op in flight
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: reset_n low asynchronously clears busy, hi, lo, the counter and the pending results to 0. Reset while busy abandons the op; no commit occurs.
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, NOP=6/7.
- Issue (MULT/MULTU/DIV/DIVU):
  - Sampled when start=1, busy=0 and cancel=0 at edge t.
  - At t, load pending_hi/pending_lo with the full result, set counter=N, set busy=1.
  - N is MULT_CYCLES for multiplies and DIV_CYCLES for divides.
  - Each later edge decrements the counter.
  - On the edge where the counter goes 1→0: busy=0 and hi/lo take the pending values in the same edge.
  - busy is therefore high for exactly N cycles after the issue edge. New hi/lo are visible in the first cycle busy=0.
- Multiply: full 2·WIDTH product. hi = upper half, lo = lower half. MULT is signed × signed; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - b=0: no error. busy still runs DIV_CYCLES, and hi/lo are unchanged at commit (pending loads the current hi/lo).
  - Signed MIN/−1: lo = MIN, hi = 0.
- MTHI/MTLO: with start=1 and busy=0, write a into hi/lo at that edge. Zero latency; busy stays 0.
- start while busy=1: ignored; the hazard unit must not allow it. Bench asserts this case is never accepted.
- cancel=1:
  - While busy: busy→0 and counter→0 at the next edge; hi/lo keep their old values.
  - Simultaneous with start: cancel wins and nothing is issued.
- Commit edge with start=1 (busy still 1 that cycle): start is ignored, so the earliest back-to-back issue is the cycle after busy falls.
- hi/lo are registered outputs and never glitch combinationally. mfhi/mflo read them directly.
- Arithmetic uses $signed/$unsigned extension to 2·WIDTH bits, computed combinationally at issue. The counter models latency only, not a real iterative datapath.

Decomposition:
- Shared package mdu_pkg: localparams for the mdu_op codes (MDU_MULT…MDU_NOP) and the default latencies. The CU imports the same codes.
- Optional sub-module e_mdu_calc: purely combinational result generator (op, a, b, old hi/lo → pending hi/lo). This keeps the div-by-zero and MIN/−1 rules in one place. The e_mdu top holds the counter, busy and HI/LO registers.

Test Plan:
- Reset mid-op: MULT issued, reset_n pulsed low 2 cycles later → busy=0, hi=lo=0 immediately (asynchronous), and no later commit.
- Signed MULT: a=0xFFFFFFFE (−2), b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Signed DIV:
  - a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles: lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: hi=0x11, lo=0x22 preloaded via MTHI/MTLO (each visible the next cycle, busy never set), then DIVU a=5, b=0 → busy 10 cycles, then hi=0x11, lo=0x22.
- Cancel: DIV issued, cancel asserted on busy cycle 4 → busy=0 next cycle and hi/lo unchanged. start together with cancel → no issue.
- Back-to-back: MULT issued; start with MTHI held during busy is ignored. MTHI issued the cycle after busy falls → hi=new a, lo keeps the product.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes and default latencies for the execute-stage multiply/divide unit.
// The control unit decodes into the same mdu_op codes.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_NOP   = 3'd6;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    MDU_KIND_NONE,
    MDU_KIND_MUL,
    MDU_KIND_DIV,
    MDU_KIND_MOVE
  } mdu_kind_e;

  // Coarse class of an op code: decides latency and whether HI/LO move directly.
  function automatic mdu_kind_e mdu_kind(input logic [2:0] op);
    mdu_kind_e kind;
    case (op)
      MDU_MULT, MDU_MULTU: kind = MDU_KIND_MUL;
      MDU_DIV,  MDU_DIVU:  kind = MDU_KIND_DIV;
      MDU_MTHI, MDU_MTLO:  kind = MDU_KIND_MOVE;
      default:             kind = MDU_KIND_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational result generator: full product or quotient/remainder for the issuing op.
// Divide-by-zero returns the current HI/LO so the later commit leaves them unchanged.
module e_mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;
  logic               b_zero;
  logic               min_by_neg1;

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed / and % truncate toward zero with the remainder following the dividend.
  assign quo_s = $signed(a) / $signed(b);
  assign rem_s = $signed(a) % $signed(b);
  assign quo_u = a / b;
  assign rem_u = a % b;

  assign b_zero      = (b == '0);
  assign min_by_neg1 = (a == MIN_NEG) && (&b);

  always_comb begin
    res_hi = hi_cur;
    res_lo = lo_cur;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        if (min_by_neg1) begin
          res_hi = '0;
          res_lo = MIN_NEG;
        end else if (!b_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MDU_DIVU: begin
        if (!b_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = hi_cur;
        res_lo = lo_cur;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: result computed at issue, committed to HI/LO
// after a fixed busy countdown; MTHI/MTLO write directly when idle.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             busy_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] pend_hi_reg;
  logic [WIDTH-1:0] pend_lo_reg;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  mdu_kind_e        op_kind;

  assign op_kind = mdu_kind(mdu_op);

  e_mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op     (mdu_op),
    .a      (a),
    .b      (b),
    .hi_cur (hi_reg),
    .lo_cur (lo_reg),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
    end else if (cancel) begin
      // Squash any in-flight op; a start in the same cycle is dropped too.
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (busy_reg) begin
      cnt_reg <= cnt_reg - ONE;
      if (cnt_reg == ONE) begin
        busy_reg <= 1'b0;
        hi_reg   <= pend_hi_reg;
        lo_reg   <= pend_lo_reg;
      end
    end else if (start) begin
      case (op_kind)
        MDU_KIND_MUL, MDU_KIND_DIV: begin
          pend_hi_reg <= calc_hi;
          pend_lo_reg <= calc_lo;
          cnt_reg     <= (op_kind == MDU_KIND_MUL) ? MULT_N : DIV_N;
          busy_reg    <= 1'b1;
        end
        MDU_KIND_MOVE: begin
          if (mdu_op == MDU_MTHI) hi_reg <= a;
          else                    lo_reg <= a;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO pushed to a scoreboard at issue,
// popped and compared when busy falls.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = MDU_NOP;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  e_mdu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdu_op  (mdu_op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] op_a, input logic [31:0] op_b);
    start  = 1'b1;
    mdu_op = op;
    a      = op_a;
    b      = op_b;
    tick(1);
    start  = 1'b0;
    mdu_op = MDU_NOP;
  endtask

  task automatic wait_commit(input int n, input string tag);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick(1);
    end
    check({tag, "_latency"}, 64'(cnt), 64'(n));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
    $display("txn %s busy_cycles=%0d hi=%h lo=%h", tag, cnt, hi, lo);
  endtask

  initial begin
    logic [31:0]        ra;
    logic [31:0]        rb;
    logic [63:0]        pu;
    logic signed [63:0] ps;

    // Power-on reset
    tick(3);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    reset_n = 1'b1;
    tick(1);

    // Reset mid-op: asynchronous clear, no later commit
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    check("rstmid_busy_set", 64'(busy), 64'(1));
    tick(1);
    #3 reset_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_hi", 64'(hi), 64'(0));
    check("rstmid_lo", 64'(lo), 64'(0));
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("rstmid_nocommit", {hi, lo}, 64'(0));
    check("rstmid_idle", 64'(busy), 64'(0));
    $display("txn reset_mid_op hi=%h lo=%h", hi, lo);

    // Signed and unsigned multiply
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_commit(5, "mult_neg2x3");
    sb.push_back('{hi: 32'h0000_0002, lo: 32'hFFFF_FFFA});
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_commit(5, "multu_fffffffex3");

    // Signed divide, including MIN / -1
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_commit(10, "div_neg7by2");
    sb.push_back('{hi: 32'h0000_0000, lo: 32'h8000_0000});
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit(10, "div_min_by_neg1");

    // MTHI/MTLO: zero latency
    issue(MDU_MTHI, 32'h11, 32'd0);
    check("mthi_busy", 64'(busy), 64'(0));
    check("mthi_hi", 64'(hi), 64'h11);
    issue(MDU_MTLO, 32'h22, 32'd0);
    check("mtlo_busy", 64'(busy), 64'(0));
    check("mtlo_lo", 64'(lo), 64'h22);
    check("mtlo_hi_kept", 64'(hi), 64'h11);
    $display("txn mthi_mtlo hi=%h lo=%h", hi, lo);

    // Divide by zero keeps HI/LO
    sb.push_back('{hi: 32'h11, lo: 32'h22});
    issue(MDU_DIVU, 32'd5, 32'd0);
    wait_commit(10, "divu_by_zero");

    // Cancel on busy cycle 4
    issue(MDU_DIV, 32'd100, 32'd7);
    tick(3);
    check("cancel_still_busy", 64'(busy), 64'(1));
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'(0));
    check("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
    tick(12);
    check("cancel_no_commit", {hi, lo}, {32'h11, 32'h22});
    $display("txn cancel_div hi=%h lo=%h", hi, lo);

    // start together with cancel issues nothing
    cancel = 1'b1;
    issue(MDU_MULT, 32'd9, 32'd9);
    check("start_cancel_busy", 64'(busy), 64'(0));
    issue(MDU_MTHI, 32'hBEEF, 32'd0);
    cancel = 1'b0;
    check("start_cancel_mthi", 64'(hi), 64'h11);
    $display("txn start_with_cancel hi=%h lo=%h", hi, lo);

    // Back-to-back: MTHI held through busy is ignored until busy falls
    sb.push_back('{hi: 32'd0, lo: 32'd42});
    issue(MDU_MULT, 32'd7, 32'd6);
    start  = 1'b1;
    mdu_op = MDU_MTHI;
    a      = 32'hDEAD;
    tick(2);
    check("b2b_busy_ignores_start", 64'(busy), 64'(1));
    check("b2b_hi_during_busy", 64'(hi), 64'h11);
    wait_commit(3, "b2b_mult");
    tick(1);
    start  = 1'b0;
    mdu_op = MDU_NOP;
    check("b2b_mthi_hi", 64'(hi), 64'hDEAD);
    check("b2b_mthi_lo", 64'(lo), 64'd42);
    check("b2b_mthi_busy", 64'(busy), 64'(0));
    $display("txn b2b_mthi hi=%h lo=%h", hi, lo);

    // Random multiplies against a 64-bit model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      pu = {32'd0, ra} * {32'd0, rb};
      sb.push_back('{hi: pu[63:32], lo: pu[31:0]});
      issue(MDU_MULTU, ra, rb);
      wait_commit(5, "multu_rand");
      ps = 64'(signed'(ra)) * 64'(signed'(rb));
      sb.push_back('{hi: ps[63:32], lo: ps[31:0]});
      issue(MDU_MULT, ra, rb);
      wait_commit(5, "mult_rand");
    end

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
